// File: rtl/mipi_csi_tx_packer.sv
// CSI-2 transmit payload packer: pixel beats -> byte FIFO -> 1/2/4 lane byte outputs.
// Define MIPI_CSI_TX_RAW10_EN to compile in RAW10 5-byte packing; otherwise RAW10 is discarded.
module mipi_csi_tx_packer (
    input  logic            clk_i,
    input  logic            reset_n_i,
    input  logic [2:0]      active_lanes_i,
    input  logic [5:0]      data_type_i,
    input  logic [47:0]     pixel_data_i,
    input  logic [2:0]      pixel_num_i,
    input  logic            pixel_valid_i,
    input  logic            pixel_last_i,
    output logic            pixel_ready_o,
    output logic [3:0][7:0] payload_data_o,
    output logic [3:0]      payload_valid_o,
    output logic            line_done_o,
    output logic            underflow_o
);

    localparam logic [5:0] DT_YUV422_8 = 6'h1E;
    localparam logic [5:0] DT_RGB565   = 6'h22;
    localparam logic [5:0] DT_RGB888   = 6'h24;
    localparam logic [5:0] DT_RAW8     = 6'h2A;
`ifdef MIPI_CSI_TX_RAW10_EN
    localparam logic [5:0] DT_RAW10    = 6'h2B;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    state_t           state_r;
    logic [4:0]       fill_r;
    logic [15:0][7:0] fifo_r;
    logic [2:0]       lanes_r;
    logic [5:0]       type_r;
    logic             started_r;

    logic             accept_s;
    logic [5:0]       cur_type_s;
    logic [2:0]       beat_len_s;
    logic             raw10_s;
    logic [5:0]       shamt_s;
    logic [47:0]      aligned_s;
    logic [47:0]      raw10_vec_s;
    logic [47:0]      beat_vec_s;
    logic [2:0]       pop_s;
    logic [2:0]       push_len_s;
    logic [4:0]       remain_s;
    logic [4:0]       off_s;
    logic [15:0][7:0] fifo_nxt_s;

    function automatic logic [2:0] lane_count(input logic [2:0] req);
        case (req)
            3'd2:    lane_count = 3'd2;
            3'd4:    lane_count = 3'd4;
            default: lane_count = 3'd1;
        endcase
    endfunction

    assign pixel_ready_o = (state_r != ST_FLUSH) && (fill_r <= 5'd10);
    assign accept_s      = pixel_valid_i && pixel_ready_o;
    assign cur_type_s    = (state_r == ST_IDLE) ? data_type_i : type_r;
    assign push_len_s    = accept_s ? beat_len_s : 3'd0;
    assign remain_s      = fill_r - {2'b00, pop_s};

`ifdef MIPI_CSI_TX_RAW10_EN
    assign raw10_vec_s = {pixel_data_i[39:32], pixel_data_i[29:22], pixel_data_i[19:12],
                          pixel_data_i[9:2], pixel_data_i[1:0], pixel_data_i[11:10],
                          pixel_data_i[21:20], pixel_data_i[31:30], 8'h00};
`else
    assign raw10_vec_s = 48'h0;
`endif

    // Beat byte count per data type; unsupported types contribute zero bytes
    always_comb begin
        beat_len_s = 3'd0;
        raw10_s    = 1'b0;
        case (cur_type_s)
            DT_YUV422_8: beat_len_s = 3'd4;
            DT_RGB888:   beat_len_s = (pixel_num_i >= 3'd2) ? 3'd6 :
                                      ((pixel_num_i == 3'd1) ? 3'd3 : 3'd0);
            DT_RGB565:   beat_len_s = (pixel_num_i >= 3'd2) ? 3'd4 :
                                      ((pixel_num_i == 3'd1) ? 3'd2 : 3'd0);
            DT_RAW8:     beat_len_s = (pixel_num_i > 3'd4) ? 3'd4 : pixel_num_i;
`ifdef MIPI_CSI_TX_RAW10_EN
            DT_RAW10: begin
                beat_len_s = 3'd5;
                raw10_s    = 1'b1;
            end
`endif
            default:     beat_len_s = 3'd0;
        endcase
    end

    // Left-justify the used low bytes so the first byte to send sits in [47:40]
    assign shamt_s    = {3'd6 - beat_len_s, 3'b000};
    assign aligned_s  = pixel_data_i << shamt_s;
    assign beat_vec_s = raw10_s ? raw10_vec_s : aligned_s;

    // Pop count from registered fill: full words in ACTIVE, a partial tail in FLUSH
    always_comb begin
        pop_s = 3'd0;
        case (state_r)
            ST_ACTIVE: begin
                if (fill_r >= {2'b00, lanes_r}) pop_s = lanes_r;
                else                            pop_s = 3'd0;
            end
            ST_FLUSH: begin
                if (fill_r >= {2'b00, lanes_r}) pop_s = lanes_r;
                else                            pop_s = fill_r[2:0];
            end
            default: pop_s = 3'd0;
        endcase
    end

    // Next FIFO image: surviving bytes shift to the front, new beat bytes appended behind them
    always_comb begin
        fifo_nxt_s = '0;
        off_s      = 5'd0;
        for (int i = 0; i < 16; i++) begin
            off_s = 5'(i) - remain_s;
            if (5'(i) < remain_s) begin
                fifo_nxt_s[i] = fifo_r[4'(i + int'(pop_s))];
            end else if (off_s < {2'b00, push_len_s}) begin
                fifo_nxt_s[i] = beat_vec_s[6'd47 - {off_s[2:0], 3'b000} -: 8];
            end else begin
                fifo_nxt_s[i] = 8'h00;
            end
        end
    end

    // Line FSM, FIFO state and registered lane outputs
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r         <= ST_IDLE;
            fill_r          <= 5'd0;
            fifo_r          <= '0;
            lanes_r         <= 3'd1;
            type_r          <= 6'd0;
            started_r       <= 1'b0;
            payload_data_o  <= '0;
            payload_valid_o <= 4'h0;
            line_done_o     <= 1'b0;
            underflow_o     <= 1'b0;
        end else begin
            fifo_r      <= fifo_nxt_s;
            fill_r      <= remain_s + {2'b00, push_len_s};
            line_done_o <= 1'b0;
            underflow_o <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < pop_s) begin
                    payload_data_o[2'(3 - i)]  <= fifo_r[4'(i)];
                    payload_valid_o[2'(3 - i)] <= 1'b1;
                end else begin
                    payload_data_o[2'(3 - i)]  <= 8'h00;
                    payload_valid_o[2'(3 - i)] <= 1'b0;
                end
            end
            case (state_r)
                ST_IDLE: begin
                    started_r <= 1'b0;
                    if (accept_s) begin
                        lanes_r <= lane_count(active_lanes_i);
                        type_r  <= data_type_i;
                        state_r <= pixel_last_i ? ST_FLUSH : ST_ACTIVE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    if (pop_s != 3'd0) started_r   <= 1'b1;
                    else if (started_r) underflow_o <= 1'b1;
                    else                underflow_o <= 1'b0;
                    if (accept_s && pixel_last_i) state_r <= ST_FLUSH;
                    else                          state_r <= ST_ACTIVE;
                end
                ST_FLUSH: begin
                    if (remain_s == 5'd0) begin
                        state_r     <= ST_IDLE;
                        line_done_o <= 1'b1;
                        started_r   <= 1'b0;
                    end else begin
                        state_r <= ST_FLUSH;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mipi_csi_tx_packer.sv
// Table-driven bench for mipi_csi_tx_packer: expected lane words are queued as beats are
// driven and popped by a monitor whenever the DUT shows output; plus a mid-line reset sequence.
module tb_mipi_csi_tx_packer;

    localparam logic [5:0] DT_YUV422_8 = 6'h1E;
    localparam logic [5:0] DT_RGB565   = 6'h22;
    localparam logic [5:0] DT_RGB888   = 6'h24;
    localparam logic [5:0] DT_RAW8     = 6'h2A;
    localparam logic [5:0] DT_RAW10    = 6'h2B;
    localparam logic [5:0] DT_BAD      = 6'h30;
    localparam int         NVEC        = 9;

    logic            clk_i = 1'b0;
    logic            reset_n_i;
    logic [2:0]      active_lanes_i;
    logic [5:0]      data_type_i;
    logic [47:0]     pixel_data_i;
    logic [2:0]      pixel_num_i;
    logic            pixel_valid_i;
    logic            pixel_last_i;
    logic            pixel_ready_o;
    logic [3:0][7:0] payload_data_o;
    logic [3:0]      payload_valid_o;
    logic            line_done_o;
    logic            underflow_o;

    always #5 clk_i = ~clk_i;

    mipi_csi_tx_packer dut (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .active_lanes_i (active_lanes_i),
        .data_type_i    (data_type_i),
        .pixel_data_i   (pixel_data_i),
        .pixel_num_i    (pixel_num_i),
        .pixel_valid_i  (pixel_valid_i),
        .pixel_last_i   (pixel_last_i),
        .pixel_ready_o  (pixel_ready_o),
        .payload_data_o (payload_data_o),
        .payload_valid_o(payload_valid_o),
        .line_done_o    (line_done_o),
        .underflow_o    (underflow_o)
    );

    typedef struct packed {
        logic [3:0][7:0] data;
        logic [3:0]      valid;
        logic            ld;
    } word_t;

    typedef struct packed {
        logic [5:0]       dt;
        logic [2:0]       lanes;
        logic [2:0]       nbeats;
        logic [3:0][47:0] data;
        logic [3:0][2:0]  num;
        logic [3:0]       stall;
        logic [4:0]       nbytes;
        logic [191:0]     ebytes;
        logic [3:0]       uf;
        logic             bp;
    } vec_t;

    vec_t  vecs [NVEC];
    word_t sb_q [$];
    int    checks = 0;
    int    errors = 0;
    int    uf_count = 0;
    logic  ready_low_seen = 1'b0;
    logic  mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [191:0] left(input logic [191:0] v, input int n);
        return v << (8 * (24 - n));
    endfunction

    function automatic int lanes_eff(input logic [2:0] l);
        if (l == 3'd2)      return 2;
        else if (l == 3'd4) return 4;
        else                return 1;
    endfunction

    // Monitor: every cycle with lane output or line_done consumes one expected word
    always @(negedge clk_i) begin
        if (mon_en) begin
            if (underflow_o) uf_count++;
            if (payload_valid_o != 4'h0 || line_done_o) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_output", {payload_data_o, payload_valid_o, line_done_o}, 64'h0);
                end else begin
                    word_t e;
                    e = sb_q.pop_front();
                    check("out_word", {payload_data_o, payload_valid_o, line_done_o}, e);
                end
            end
        end
    end

    task automatic push_line(input vec_t v);
        int    n;
        int    total;
        int    i;
        word_t w;
        n     = lanes_eff(v.lanes);
        total = int'(v.nbytes);
        i     = 0;
        if (total == 0) begin
            w    = '0;
            w.ld = 1'b1;
            sb_q.push_back(w);
        end
        while (i < total) begin
            w = '0;
            for (int k = 0; k < n; k++) begin
                if (i + k < total) begin
                    w.data[3 - k]  = v.ebytes[191 - 8 * (i + k) -: 8];
                    w.valid[3 - k] = 1'b1;
                end
            end
            i += n;
            w.ld = (i >= total);
            sb_q.push_back(w);
        end
    endtask

    task automatic drive_beat(input logic [47:0] d, input logic [2:0] n, input logic last);
        int   guard;
        logic done;
        guard         = 0;
        done          = 1'b0;
        pixel_data_i  = d;
        pixel_num_i   = n;
        pixel_last_i  = last;
        pixel_valid_i = 1'b1;
        while (!done) begin
            @(negedge clk_i);
            if (pixel_ready_o) begin
                @(posedge clk_i);
                done = 1'b1;
            end else begin
                ready_low_seen = 1'b1;
                guard++;
                if (guard > 200) begin
                    check("ready_timeout", 64'd1, 64'd0);
                    done = 1'b1;
                end
            end
        end
        #1;
        pixel_valid_i = 1'b0;
        pixel_last_i  = 1'b0;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (sb_q.size() != 0 && g < 300) begin
            @(posedge clk_i);
            g++;
        end
        check("drain", sb_q.size(), 64'd0);
        sb_q.delete();
        repeat (3) @(posedge clk_i);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        push_line(v);
        uf_count       = 0;
        ready_low_seen = 1'b0;
        for (int b = 0; b < int'(v.nbeats); b++) begin
            if (b == 0) begin
                active_lanes_i = v.lanes;
                data_type_i    = v.dt;
            end else begin
                active_lanes_i = (v.lanes == 3'd4) ? 3'd1 : 3'd4;
                data_type_i    = 6'h00;
            end
            drive_beat(v.data[b], v.num[b], b == int'(v.nbeats) - 1);
            if (b == 0 && v.stall != 4'd0) begin
                repeat (int'(v.stall)) @(posedge clk_i);
                #1;
            end
        end
        wait_drain();
        check("underflow_count", uf_count, v.uf);
        check("ready_backpressure", ready_low_seen, v.bp);
    endtask

    initial begin
        word_t w;
        for (int i = 0; i < NVEC; i++) vecs[i] = '0;
        // RAW8, 4 lanes, two beats
        vecs[0].dt = DT_RAW8; vecs[0].lanes = 3'd4; vecs[0].nbeats = 3'd2;
        vecs[0].data[0] = 48'h01020304; vecs[0].num[0] = 3'd4;
        vecs[0].data[1] = 48'h05060708; vecs[0].num[1] = 3'd4;
        vecs[0].nbytes = 5'd8; vecs[0].ebytes = left(192'h0102030405060708, 8);
        // RAW10, 2 lanes, single beat
        vecs[1].dt = DT_RAW10; vecs[1].lanes = 3'd2; vecs[1].nbeats = 3'd1;
        vecs[1].data[0] = {8'h00, 10'h3FF, 10'h001, 10'h2AA, 10'h155}; vecs[1].num[0] = 3'd4;
`ifdef MIPI_CSI_TX_RAW10_EN
        vecs[1].nbytes = 5'd5; vecs[1].ebytes = left(192'hFF00AA5567, 5);
`else
        vecs[1].nbytes = 5'd0;
`endif
        // RGB888, 1 lane, 1-pixel beats
        vecs[2].dt = DT_RGB888; vecs[2].lanes = 3'd1; vecs[2].nbeats = 3'd2;
        vecs[2].data[0] = 48'hA1B2C3; vecs[2].num[0] = 3'd1;
        vecs[2].data[1] = 48'hD4E5F6; vecs[2].num[1] = 3'd1;
        vecs[2].nbytes = 5'd6; vecs[2].ebytes = left(192'hA1B2C3D4E5F6, 6);
        // YUV422, 4 lanes, 3-cycle source stall after the first beat
        vecs[3].dt = DT_YUV422_8; vecs[3].lanes = 3'd4; vecs[3].nbeats = 3'd3; vecs[3].stall = 4'd3;
        vecs[3].data[0] = 48'h11223344; vecs[3].num[0] = 3'd2;
        vecs[3].data[1] = 48'h55667788; vecs[3].num[1] = 3'd2;
        vecs[3].data[2] = 48'h99AABBCC; vecs[3].num[2] = 3'd2;
        vecs[3].nbytes = 5'd12; vecs[3].ebytes = left(192'h112233445566778899AABBCC, 12);
        vecs[3].uf = 4'd3;
        // RGB888 2-pixel beats on 1 lane: backpressure
        vecs[4].dt = DT_RGB888; vecs[4].lanes = 3'd1; vecs[4].nbeats = 3'd4;
        vecs[4].data[0] = 48'h010203040506; vecs[4].num[0] = 3'd2;
        vecs[4].data[1] = 48'h0708090A0B0C; vecs[4].num[1] = 3'd2;
        vecs[4].data[2] = 48'h0D0E0F101112; vecs[4].num[2] = 3'd2;
        vecs[4].data[3] = 48'h131415161718; vecs[4].num[3] = 3'd2;
        vecs[4].nbytes = 5'd24;
        vecs[4].ebytes = left(192'h0102030405060708090A0B0C0D0E0F101112131415161718, 24);
        vecs[4].bp = 1'b1;
        // RGB565, 2 lanes, 2-pixel then 1-pixel beat
        vecs[5].dt = DT_RGB565; vecs[5].lanes = 3'd2; vecs[5].nbeats = 3'd2;
        vecs[5].data[0] = 48'hABCD1234; vecs[5].num[0] = 3'd2;
        vecs[5].data[1] = 48'h5678; vecs[5].num[1] = 3'd1;
        vecs[5].nbytes = 5'd6; vecs[5].ebytes = left(192'hABCD12345678, 6);
        // RAW8, 2 lanes, odd byte count -> partial final word
        vecs[6].dt = DT_RAW8; vecs[6].lanes = 3'd2; vecs[6].nbeats = 3'd1;
        vecs[6].data[0] = 48'h0A0B0C; vecs[6].num[0] = 3'd3;
        vecs[6].nbytes = 5'd3; vecs[6].ebytes = left(192'h0A0B0C, 3);
        // Unsupported data type: discarded, line_done only
        vecs[7].dt = DT_BAD; vecs[7].lanes = 3'd4; vecs[7].nbeats = 3'd2;
        vecs[7].data[0] = 48'hDEADBEEF; vecs[7].num[0] = 3'd4;
        vecs[7].data[1] = 48'hCAFEF00D; vecs[7].num[1] = 3'd4;
        vecs[7].nbytes = 5'd0;
        // Illegal lane count 3 behaves as 1 lane
        vecs[8].dt = DT_RAW8; vecs[8].lanes = 3'd3; vecs[8].nbeats = 3'd1;
        vecs[8].data[0] = 48'hC0FFEE; vecs[8].num[0] = 3'd3;
        vecs[8].nbytes = 5'd3; vecs[8].ebytes = left(192'hC0FFEE, 3);

        reset_n_i      = 1'b0;
        active_lanes_i = 3'd1;
        data_type_i    = 6'h00;
        pixel_data_i   = 48'h0;
        pixel_num_i    = 3'd0;
        pixel_valid_i  = 1'b0;
        pixel_last_i   = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_outputs", {payload_data_o, payload_valid_o, line_done_o, underflow_o}, 64'h0);
        check("reset_ready", pixel_ready_o, 64'd1);
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        mon_en    = 1'b1;

        for (int v = 0; v < NVEC; v++) run_vec(vecs[v]);

        // Abort a RAW8 1-lane line with 7 bytes buffered
        w = '0;
        w.data[3]  = 8'h01;
        w.valid[3] = 1'b1;
        sb_q.push_back(w);
        active_lanes_i = 3'd1;
        data_type_i    = DT_RAW8;
        drive_beat(48'h01020304, 3'd4, 1'b0);
        drive_beat(48'h05060708, 3'd4, 1'b0);
        check("fill_before_reset", dut.fill_r, 64'd7);
        reset_n_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        check("abort_outputs", {payload_data_o, payload_valid_o, line_done_o, underflow_o}, 64'h0);
        check("abort_fill", dut.fill_r, 64'd0);
        check("abort_ready", pixel_ready_o, 64'd1);
        check("abort_queue", sb_q.size(), 64'd0);
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        repeat (5) @(posedge clk_i);
        #1;
        run_vec(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
